// File: rtl/keypad_code_entry.sv
`default_nettype none
// ============================================================================
// Module      : keypad_code_entry
// Description : Bit-serial keypad front end for Digital_Lock. Builds a code,
//               presents it, judges the response and enforces a lockout.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_code_entry #(
    parameter int CODE_W         = 4,
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_valid,
    input  logic              key_bit,
    input  logic              key_clear,
    input  logic              key_enter,
    input  logic              unlock,
    input  logic              alarm,
    output logic [CODE_W-1:0] input_code,
    output logic              code_valid,
    output logic              granted,
    output logic              denied,
    output logic              lockout,
    output logic [3:0]        fail_count
);

    localparam int c_CNT_W = $clog2(CODE_W + 1);
    localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(CODE_W);
    localparam logic [3:0]         c_MAX      = 4'(MAX_TRIES);
    localparam logic [15:0]        c_LOCK_LEN = 16'(LOCKOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COLLECT   = 3'd1,
        S_PRESENT   = 3'd2,
        S_WAIT_RESP = 3'd3,
        S_LOCKOUT   = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic [CODE_W-1:0]    r_shift;
    logic [CODE_W-1:0]    w_shift_nx;
    logic [CODE_W-1:0]    w_shift_in;
    logic [c_CNT_W-1:0]   r_bit_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nx;
    logic [15:0]          r_timer;
    logic [15:0]          w_timer_nx;
    logic [CODE_W-1:0]    w_code_nx;
    logic [3:0]           w_fail_nx;
    logic [3:0]           w_fail_inc;
    logic                 w_granted_nx;
    logic                 w_denied_nx;

    assign w_shift_in = (r_shift << 1) | CODE_W'(key_bit);
    assign w_fail_inc = (fail_count == 4'd15) ? 4'd15 : fail_count + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_timer    <= '0;
            input_code <= '0;
            fail_count <= '0;
            code_valid <= 1'b0;
            granted    <= 1'b0;
            denied     <= 1'b0;
            lockout    <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_shift    <= w_shift_nx;
            r_bit_cnt  <= w_cnt_nx;
            r_timer    <= w_timer_nx;
            input_code <= w_code_nx;
            fail_count <= w_fail_nx;
            code_valid <= (w_state_nx == S_PRESENT);
            granted    <= w_granted_nx;
            denied     <= w_denied_nx;
            lockout    <= (w_state_nx == S_LOCKOUT);
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_shift_nx   = r_shift;
        w_cnt_nx     = r_bit_cnt;
        w_timer_nx   = r_timer;
        w_code_nx    = input_code;
        w_fail_nx    = fail_count;
        w_granted_nx = 1'b0;
        w_denied_nx  = 1'b0;

        case (r_state)
            S_IDLE: begin
                // clear/enter outrank key_valid even though they do nothing here
                if (!key_clear && !key_enter && key_valid) begin
                    w_shift_nx = w_shift_in;
                    w_cnt_nx   = c_CNT_W'(1);
                    w_state_nx = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (key_clear) begin
                    w_state_nx = S_IDLE;
                end else if (key_enter) begin
                    if (r_bit_cnt == c_FULL) begin
                        w_code_nx  = r_shift;
                        w_state_nx = S_PRESENT;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end else if (key_valid && (r_bit_cnt < c_FULL)) begin
                    w_shift_nx = w_shift_in;
                    w_cnt_nx   = r_bit_cnt + c_CNT_W'(1);
                end
            end
            S_PRESENT: begin
                w_state_nx = S_WAIT_RESP;
            end
            S_WAIT_RESP: begin
                if (unlock && !alarm) begin
                    w_granted_nx = 1'b1;
                    w_fail_nx    = 4'd0;
                    w_state_nx   = S_IDLE;
                end else begin
                    w_denied_nx = 1'b1;
                    w_fail_nx   = w_fail_inc;
                    if (alarm || (w_fail_inc >= c_MAX)) begin
                        w_timer_nx = c_LOCK_LEN;
                        w_state_nx = S_LOCKOUT;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end
            end
            S_LOCKOUT: begin
                // timer counts LOCKOUT_CYCLES..1, one lockout cycle per value
                if (r_timer <= 16'd1) begin
                    w_timer_nx = 16'd0;
                    w_fail_nx  = 4'd0;
                    w_state_nx = S_IDLE;
                end else begin
                    w_timer_nx = r_timer - 16'd1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        if (w_state_nx == S_IDLE) begin
            w_shift_nx = '0;
            w_cnt_nx   = '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_code_entry.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_code_entry
// Description : Randomized scoreboard bench for keypad_code_entry against an
//               attempt-level reference model and a 1010 combinational lock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_code_entry;

    localparam int         c_CODE_W = 4;
    localparam int         c_MAX    = 3;
    localparam int         c_LOCK   = 16;
    localparam logic [3:0] c_PASS   = 4'b1010;

    typedef struct {
        int kind;   // 0 code, 1 granted, 2 denied, 3 lockout end
        int val;
        int fc;
    } ev_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              key_valid = 1'b0;
    logic              key_bit = 1'b0;
    logic              key_clear = 1'b0;
    logic              key_enter = 1'b0;
    logic              alarm = 1'b0;
    logic              unlock;
    logic [c_CODE_W-1:0] input_code;
    logic              code_valid;
    logic              granted;
    logic              denied;
    logic              lockout;
    logic [3:0]        fail_count;

    int errors = 0;
    int checks = 0;

    ev_t exp_q[$];
    bit  m_bits[$];
    int  m_fc = 0;
    int  m_blocked_until = 0;
    bit  m_pend = 1'b0;
    int  m_pend_t = 0;
    int  m_pend_code = 0;
    int  cyc = 0;
    int  lcnt = 0;

    keypad_code_entry #(
        .CODE_W(c_CODE_W), .MAX_TRIES(c_MAX), .LOCKOUT_CYCLES(c_LOCK)
    ) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_bit(key_bit),
        .key_clear(key_clear), .key_enter(key_enter), .unlock(unlock),
        .alarm(alarm), .input_code(input_code), .code_valid(code_valid),
        .granted(granted), .denied(denied), .lockout(lockout),
        .fail_count(fail_count)
    );

    // Digital_Lock stand-in: combinational match against the password
    assign unlock = (input_code == c_PASS);

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic pop_check(input int kind, input int val, input int fc);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            if (e.kind == kind) begin
                if (kind == 0 || kind == 3) check(kind == 0 ? "input_code" : "lockout_len", val, e.val);
                if (kind != 0) check("fail_count", fc, e.fc);
            end
        end
    endtask

    // Monitor: consumes expected events as the DUT presents them
    always @(negedge clk) begin
        if (reset) begin
            lcnt = 0;
        end else begin
            if (code_valid) pop_check(0, int'(input_code), 0);
            if (granted)    pop_check(1, 0, int'(fail_count));
            if (denied)     pop_check(2, 0, int'(fail_count));
            if (lockout) begin
                lcnt++;
            end else if (lcnt > 0) begin
                pop_check(3, lcnt, int'(fail_count));
                lcnt = 0;
            end
        end
    end

    // Reference model: one attempt judged two cycles after enter, keys
    // ignored until the response cycle (plus any lockout) has passed.
    task automatic model_resolve(input bit a);
        ev_t e;
        if (m_pend_code == int'(c_PASS) && !a) begin
            m_fc = 0;
            e = '{1, 0, 0};
            exp_q.push_back(e);
        end else begin
            m_fc = (m_fc >= 15) ? 15 : m_fc + 1;
            e = '{2, 0, m_fc};
            exp_q.push_back(e);
            if (a || m_fc >= c_MAX) begin
                e = '{3, c_LOCK, 0};
                exp_q.push_back(e);
                m_blocked_until = cyc + 1 + c_LOCK;
                m_fc = 0;
            end
        end
        m_pend = 1'b0;
    endtask

    task automatic step(input bit v, input bit b, input bit c, input bit e, input bit a);
        ev_t ev;
        int  code;
        key_valid = v; key_bit = b; key_clear = c; key_enter = e; alarm = a;
        if (m_pend && cyc == m_pend_t) model_resolve(a);
        if (cyc >= m_blocked_until) begin
            if (c) begin
                m_bits.delete();
            end else if (e) begin
                if (m_bits.size() == c_CODE_W) begin
                    code = 0;
                    foreach (m_bits[i]) code = (code << 1) | int'(m_bits[i]);
                    ev = '{0, code, 0};
                    exp_q.push_back(ev);
                    m_pend = 1'b1;
                    m_pend_t = cyc + 2;
                    m_pend_code = code;
                    m_blocked_until = cyc + 3;
                end
                m_bits.delete();
            end else if (v && m_bits.size() < c_CODE_W) begin
                m_bits.push_back(b);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        key_valid = 1'b0; key_clear = 1'b0; key_enter = 1'b0; alarm = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        key_valid = 1'b0; key_clear = 1'b0; key_enter = 1'b0; alarm = 1'b0;
        @(posedge clk);
        #1;
        check("rst_input_code", int'(input_code), 0);
        check("rst_code_valid", int'(code_valid), 0);
        check("rst_granted", int'(granted), 0);
        check("rst_denied", int'(denied), 0);
        check("rst_lockout", int'(lockout), 0);
        check("rst_fail_count", int'(fail_count), 0);
        exp_q.delete();
        m_bits.delete();
        m_fc = 0;
        m_pend = 1'b0;
        cyc++;
        m_blocked_until = cyc;
        reset = 1'b0;
    endtask

    task automatic enter_code(input logic [3:0] code, input bit alarm_resp);
        logic [3:0] cv;
        cv = code;
        for (int i = c_CODE_W - 1; i >= 0; i--) step(1'b1, cv[i], 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, alarm_resp);
    endtask

    task automatic random_steps(input int n);
        int r;
        for (int i = 0; i < n; i++) begin
            r = int'($urandom_range(0, 99));
            step(r < 70, 1'($urandom), r >= 94, (r >= 78 && r < 94),
                 ($urandom_range(0, 9) == 0));
        end
    endtask

    initial begin
        do_reset();

        // correct code, then two wrong ones, then a third causing lockout
        enter_code(4'b1010, 1'b0);
        enter_code(4'b1100, 1'b0);
        enter_code(4'b0110, 1'b0);
        check("no_lockout_at_2", int'(lockout), 0);
        check("fail_count_2", int'(fail_count), 2);
        enter_code(4'b1111, 1'b0);
        random_steps(c_LOCK);
        enter_code(4'b1010, 1'b0);

        // clear, short entry, over-long entry
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        enter_code(4'b1010, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        random_steps(3);

        // same-cycle strobes: clear beats valid, enter beats valid
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        random_steps(3);

        // alarm with a correct code and fail_count 0, then reset mid-lockout
        enter_code(4'b1010, 1'b1);
        check("alarm_lockout", int'(lockout), 1);
        random_steps(5);
        do_reset();
        enter_code(4'b1010, 1'b0);

        for (int k = 0; k < 40; k++) begin
            random_steps(int'($urandom_range(5, 25)));
            if ($urandom_range(0, 2) == 0) enter_code(c_PASS, ($urandom_range(0, 7) == 0));
        end

        for (int i = 0; i < c_LOCK + 8; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("events_outstanding", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
